mult_scheduler: RTL and testbench

Issue scheduler for the pipelined 64-bit integer multiplier in the Tomasulo back end. Round-robin arbitrates up to NUM_REQ multiply reservation-station entries onto the multiplier's single start port. A tag pipeline runs alongside the multiplier's fixed latency, and a credit-protected result buffer holds tagged products until the CDB accepts them. The multiplier cannot stall, so the scheduler issues only when buffer space is reserved for the result.

---
 rtl/mult_scheduler.sv | 169 ++++++++++++++++
 tb/tb_mult_scheduler.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_scheduler.sv
// Round-robin issue scheduler for the fixed-latency 64-bit multiplier with a tag pipeline
// and credit-protected result buffer. Define MULT_SCHED_BYPASS_EN to let results skip an empty buffer.
module mult_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int TAG_W      = 6,
  parameter int LATENCY    = 8,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*64-1:0]    req_mcand,
  input  logic [NUM_REQ*64-1:0]    req_mplier,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic                     mul_start,
  output logic [63:0]              mul_mcand,
  output logic [63:0]              mul_mplier,
  input  logic                     mul_done,
  input  logic [63:0]              mul_product,
  output logic                     cdb_valid,
  output logic [63:0]              cdb_value,
  output logic [TAG_W-1:0]         cdb_tag,
  input  logic                     cdb_ack,
  output logic                     err
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int OB_W  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(LATENCY + OBUF_DEPTH + 1);

  // Handshakes: a requester's operation is consumed in any cycle its req_grant bit is high
  // (grant implies req_valid); a result transfers to the CDB in any cycle cdb_valid & cdb_ack.
  logic [PTR_W-1:0]  rr_ptr, grant_idx, cand;
  logic              grant_any, can_issue, pop, bypass, fifo_push, fifo_pop, head_valid;
  logic [CNT_W-1:0]  inflight, obuf_count;
  logic [CNT_W:0]    occ;
  logic [TAG_W-1:0]  grant_tag;
  logic [LATENCY-1:0] tag_v;
  logic [TAG_W-1:0]  tag_q [LATENCY];
  logic              last_v;
  logic [TAG_W-1:0]  last_tag;
  logic [63:0]       buf_value [OBUF_DEPTH];
  logic [TAG_W-1:0]  buf_tag [OBUF_DEPTH];
  logic [OB_W-1:0]   rd_ptr, wr_ptr;

  function automatic logic [OB_W-1:0] next_ptr(input logic [OB_W-1:0] p);
    return (p == OB_W'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every started multiply holds a buffer credit until its result leaves for the CDB.
  assign occ       = {1'b0, inflight} + {1'b0, obuf_count};
  assign pop       = cdb_valid & cdb_ack;
  assign can_issue = (occ < ((CNT_W+1)'(OBUF_DEPTH) + {{CNT_W{1'b0}}, pop})) & ~reset;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign req_grant = (can_issue & grant_any) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign mul_start = |req_grant;

  always_comb begin
    mul_mcand  = '0;
    mul_mplier = '0;
    grant_tag  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_grant[i]) begin
        mul_mcand  = req_mcand[i*64 +: 64];
        mul_mplier = req_mplier[i*64 +: 64];
        grant_tag  = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (mul_start) begin
      rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= mul_start;
      for (int i = 1; i < LATENCY; i++) tag_v[i] <= tag_v[i-1];
    end
  end

  always_ff @(posedge clock) begin
    tag_q[0] <= grant_tag;
    for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
  end

  assign last_v   = tag_v[LATENCY-1];
  assign last_tag = tag_q[LATENCY-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= '0;
    end else if (mul_start & ~last_v) begin
      inflight <= inflight + 1'b1;
    end else if (~mul_start & last_v) begin
      inflight <= inflight - 1'b1;
    end
  end

  assign head_valid = (obuf_count != '0);

`ifdef MULT_SCHED_BYPASS_EN
  // A result arriving at an empty buffer is offered in its done cycle.
  assign bypass    = ~head_valid & mul_done & ~reset;
  assign cdb_valid = head_valid | bypass;
  assign cdb_value = bypass ? mul_product : (head_valid ? buf_value[rd_ptr] : '0);
  assign cdb_tag   = bypass ? last_tag : (head_valid ? buf_tag[rd_ptr] : '0);
`else
  assign bypass    = 1'b0;
  assign cdb_valid = head_valid;
  assign cdb_value = head_valid ? buf_value[rd_ptr] : '0;
  assign cdb_tag   = head_valid ? buf_tag[rd_ptr] : '0;
`endif

  assign fifo_push = mul_done & ~(bypass & cdb_ack);
  assign fifo_pop  = pop & ~bypass;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      obuf_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= next_ptr(wr_ptr);
      if (fifo_pop) rd_ptr <= next_ptr(rd_ptr);
      if (fifo_push & ~fifo_pop) begin
        obuf_count <= obuf_count + 1'b1;
      end else if (~fifo_push & fifo_pop) begin
        obuf_count <= obuf_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_push) begin
      buf_value[wr_ptr] <= mul_product;
      buf_tag[wr_ptr]   <= last_tag;
    end
  end

  // A done without a matching tag, or a tag without a done, means the latency is misconfigured.
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (mul_done != last_v) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler: a behavioural fixed-latency multiplier feeds results
// back, and per-scenario tasks compare grants, results, credits and the error flag.
`timescale 1ns/1ps
module tb_mult_scheduler;
  localparam int NUM_REQ    = 4;
  localparam int TAG_W      = 6;
  localparam int LATENCY    = 8;
  localparam int OBUF_DEPTH = 4;
`ifdef MULT_SCHED_BYPASS_EN
  localparam int RES_LAT = LATENCY;
`else
  localparam int RES_LAT = LATENCY + 1;
`endif

  logic                     clock;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*64-1:0]    req_mcand;
  logic [NUM_REQ*64-1:0]    req_mplier;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]       req_grant;
  logic                     mul_start;
  logic [63:0]              mul_mcand;
  logic [63:0]              mul_mplier;
  logic                     mul_done;
  logic [63:0]              mul_product;
  logic                     cdb_valid;
  logic [63:0]              cdb_value;
  logic [TAG_W-1:0]         cdb_tag;
  logic                     cdb_ack;
  logic                     err;
  logic                     force_done;

  int checks = 0;
  int failures = 0;
  logic [TAG_W+63:0] exp_q[$];

  mult_scheduler #(
    .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .LATENCY(LATENCY), .OBUF_DEPTH(OBUF_DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_mcand(req_mcand), .req_mplier(req_mplier), .req_tag(req_tag),
    .req_grant(req_grant), .mul_start(mul_start), .mul_mcand(mul_mcand), .mul_mplier(mul_mplier),
    .mul_done(mul_done), .mul_product(mul_product),
    .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_tag(cdb_tag), .cdb_ack(cdb_ack),
    .err(err)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural multiplier, cleared by reset like the real one
  logic [LATENCY-1:0] mv;
  logic [63:0]        mp [LATENCY];
  always @(posedge clock) begin
    if (reset) mv <= '0;
    else mv <= {mv[LATENCY-2:0], mul_start};
    mp[0] <= mul_mcand * mul_mplier;
    for (int i = 1; i < LATENCY; i++) mp[i] <= mp[i-1];
  end
  assign mul_done    = mv[LATENCY-1] | force_done;
  assign mul_product = mp[LATENCY-1];

  // driver tasks
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    req_valid  = '0;
    req_mcand  = '0;
    req_mplier = '0;
    req_tag    = '0;
    cdb_ack    = 1'b0;
    force_done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] t);
    req_mcand[i*64 +: 64]       = a;
    req_mplier[i*64 +: 64]      = b;
    req_tag[i*TAG_W +: TAG_W]   = t;
  endtask

  task automatic test_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    req_valid = '1;
    set_op(0, 64'd4, 64'd4, 6'd1);
    tick();
    #1;
    checks++;
    if (req_grant !== 4'b0000 || mul_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_grant: grant=%b start=%b expected 0000/0", req_grant, mul_start);
    end
    tick();
    reset = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: cdb_valid=%b err=%b expected 0/0", cdb_valid, err);
    end
    checks++;
    if (mul_mcand !== 64'd0 || mul_mplier !== 64'd0 || cdb_value !== 64'd0 || cdb_tag !== '0) begin
      failures++;
      $display("FAIL reset_data: mcand=%h mplier=%h value=%h tag=%h expected all 0",
               mul_mcand, mul_mplier, cdb_value, cdb_tag);
    end
  endtask

  task automatic test_single();
    int n;
    bit found;
    do_reset();
    cdb_ack = 1'b1;
    req_valid = 4'b0001;
    set_op(0, 64'd3, 64'd5, 6'd9);
    #1;
    checks++;
    if (req_grant !== 4'b0001 || mul_start !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: grant=%b start=%b expected 0001/1", req_grant, mul_start);
    end
    checks++;
    if (mul_mcand !== 64'd3 || mul_mplier !== 64'd5) begin
      failures++;
      $display("FAIL single_operands: mcand=%0d mplier=%0d expected 3/5", mul_mcand, mul_mplier);
    end
    tick();
    req_valid = '0;
    #1;
    n = 1;
    found = 0;
    while (n <= 30 && !found) begin
      if (cdb_valid === 1'b1) found = 1;
      else begin
        tick();
        #1;
        n++;
      end
    end
    checks++;
    if (!found || n != RES_LAT) begin
      failures++;
      $display("FAIL single_latency: found=%0d cycles=%0d expected %0d", found, n, RES_LAT);
    end
    checks++;
    if (cdb_value !== 64'd15 || cdb_tag !== 6'd9) begin
      failures++;
      $display("FAIL single_result: value=%0d tag=%0d expected 15/9", cdb_value, cdb_tag);
    end
    tick();
    #1;
    checks++;
    if (cdb_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain: cdb_valid=%b expected 0", cdb_valid);
    end
  endtask

  task automatic test_round_robin();
    int gcount;
    int cyc;
    int g;
    logic [NUM_REQ-1:0] expg;
    logic [TAG_W+63:0] exp;
    do_reset();
    exp_q.delete();
    cdb_ack = 1'b1;
    gcount = 0;
    cyc = 0;
    while ((gcount < 8 || exp_q.size() != 0) && cyc < 200) begin
      if (gcount < 8) begin
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++)
          set_op(i, 64'(gcount*16 + i + 1), 64'(i + 3), TAG_W'(gcount*4 + i));
      end else begin
        req_valid = '0;
      end
      #1;
      if (req_grant !== '0) begin
        g = gcount % NUM_REQ;
        expg = 4'b0001 << g;
        checks++;
        if (req_grant !== expg) begin
          failures++;
          $display("FAIL rr_grant%0d: grant=%b expected %b", gcount, req_grant, expg);
        end
        exp_q.push_back({TAG_W'(gcount*4 + g), 64'((gcount*16 + g + 1) * (g + 3))});
        gcount++;
      end
      if (cdb_valid === 1'b1 && cdb_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rr_spurious: unexpected result tag=%0d value=%0d", cdb_tag, cdb_value);
        end else begin
          exp = exp_q.pop_front();
          if ({cdb_tag, cdb_value} !== exp) begin
            failures++;
            $display("FAIL rr_result: tag=%0d value=%0d expected tag=%0d value=%0d",
                     cdb_tag, cdb_value, exp[TAG_W+63:64], exp[63:0]);
          end
        end
      end
      tick();
      cyc++;
    end
    req_valid = '0;
    checks++;
    if (gcount != 8 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rr_timeout: grants=%0d pending=%0d expected 8/0", gcount, exp_q.size());
    end
  endtask

  task automatic test_credit();
    int gcount;
    do_reset();
    cdb_ack = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 64'(i + 1), 64'd7, TAG_W'(i + 20));
    gcount = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_grant !== '0) gcount++;
      tick();
    end
    checks++;
    if (gcount != OBUF_DEPTH) begin
      failures++;
      $display("FAIL credit_count: grants=%0d expected %0d", gcount, OBUF_DEPTH);
    end
    #1;
    checks++;
    if (req_grant !== 4'b0000) begin
      failures++;
      $display("FAIL credit_stall: grant=%b expected 0000", req_grant);
    end
    checks++;
    if (cdb_valid !== 1'b1 || cdb_value !== 64'd7 || cdb_tag !== 6'd20) begin
      failures++;
      $display("FAIL credit_head: valid=%b value=%0d tag=%0d expected 1/7/20",
               cdb_valid, cdb_value, cdb_tag);
    end
    cdb_ack = 1'b1;
    #1;
    checks++;
    if (req_grant !== 4'b0001) begin
      failures++;
      $display("FAIL credit_ack_grant: grant=%b expected 0001", req_grant);
    end
    tick();
    cdb_ack = 1'b0;
    #1;
    checks++;
    if (req_grant !== 4'b0000) begin
      failures++;
      $display("FAIL credit_after_ack: grant=%b expected 0000", req_grant);
    end
    checks++;
    if (cdb_valid !== 1'b1 || cdb_value !== 64'd14 || cdb_tag !== 6'd21) begin
      failures++;
      $display("FAIL credit_next_head: valid=%b value=%0d tag=%0d expected 1/14/21",
               cdb_valid, cdb_value, cdb_tag);
    end
    req_valid = '0;
  endtask

  task automatic test_wide_product();
    int n;
    do_reset();
    cdb_ack = 1'b1;
    req_valid = 4'b0001;
    set_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd5);
    tick();
    req_valid = '0;
    #1;
    n = 1;
    while (n <= 30 && cdb_valid !== 1'b1) begin
      tick();
      #1;
      n++;
    end
    checks++;
    if (cdb_valid !== 1'b1 || cdb_value !== 64'hFFFF_FFFF_FFFF_FFFE || cdb_tag !== 6'd5) begin
      failures++;
      $display("FAIL wide_product: valid=%b value=%h tag=%0d expected 1/fffffffffffffffe/5",
               cdb_valid, cdb_value, cdb_tag);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    int gcount;
    int bad;
    do_reset();
    cdb_ack = 1'b1;
    req_valid = 4'b0111;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 64'(i + 9), 64'd3, TAG_W'(i + 40));
    gcount = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (mul_start === 1'b1) gcount++;
      tick();
    end
    req_valid = '0;
    checks++;
    if (gcount != 3) begin
      failures++;
      $display("FAIL midflight_issue: starts=%0d expected 3", gcount);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      #1;
      if (cdb_valid !== 1'b0 || err !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midflight_quiet: %0d cycles with cdb_valid or err set, expected 0", bad);
    end
    req_valid = '1;
    #1;
    checks++;
    if (req_grant !== 4'b0001) begin
      failures++;
      $display("FAIL midflight_rr: grant=%b expected 0001", req_grant);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_err();
    do_reset();
    force_done = 1'b1;
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_not_yet: err=%b expected 0", err);
    end
    tick();
    force_done = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_rise: err=%b expected 1", err);
    end
    tick();
    tick();
    tick();
    #1;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: err=%b expected 1", err);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_cleared: err=%b expected 0", err);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_credit();
    test_wide_product();
    test_reset_midflight();
    test_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
